// File: rtl/mem_bist_ctrl.sv
// rtl/mem_bist_ctrl.sv - built-in self-test sequencer for a ROM/RAM memory module
module mem_bist_ctrl #(
    parameter int ADDR_BITS    = 16,
    parameter int DATA_BITS    = 8,
    parameter int ROM_SIZE     = 1024,
    parameter int ROM_TEST_LEN = 16,
    parameter int RAM_TEST_LEN = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] mem_rdata,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [DATA_BITS-1:0] mem_wdata,
    output logic                 mem_we,
    output logic                 mem_cs,
    output logic                 mem_clr,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2:0]           err_code,
    output logic [ADDR_BITS-1:0] err_addr,
    output logic [15:0]          rom_sum
);

    typedef enum logic [3:0] {
        IDLE, ROM_RD1, ROM_WR, ROM_RD2, RAM_WR, RAM_RD,
        CLR, GAP, RAM_RD0, ROM_RD3, DONE
    } state_t;

    localparam logic [ADDR_BITS-1:0] ROM_LAST = ADDR_BITS'(ROM_TEST_LEN - 1);
    localparam logic [ADDR_BITS-1:0] RAM_LAST = ADDR_BITS'(RAM_TEST_LEN - 1);
    localparam logic [ADDR_BITS-1:0] RAM_BASE = ADDR_BITS'(ROM_SIZE);

    state_t                 state, next_state;
    logic [ADDR_BITS-1:0]   cnt;
    logic                   rd_b;
    logic [15:0]            acc;
    logic [15:0]            sum_now;
    logic [DATA_BITS-1:0]   pat;
    logic                   rd_phase;
    logic                   rom_last, ram_last;
    logic                   fail;
    logic [2:0]             fail_code;
    logic                   start_ok;

    assign busy     = (state != IDLE) && (state != DONE);
    assign start_ok = start && !busy;

    // Memory pins are decoded straight from state so an async reset idles them at once.
    always_comb begin
        next_state = state;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_we     = 1'b0;
        mem_cs     = 1'b0;
        mem_clr    = 1'b0;
        rd_phase   = 1'b0;
        fail       = 1'b0;
        fail_code  = 3'd0;
        sum_now    = acc + 16'(mem_rdata);
        pat        = DATA_BITS'(cnt) + DATA_BITS'(1);
        rom_last   = (cnt == ROM_LAST);
        ram_last   = (cnt == RAM_LAST);
        case (state)
            IDLE, DONE: begin
                if (start) next_state = ROM_RD1;
            end
            ROM_RD1: begin
                mem_cs   = 1'b1;
                mem_addr = cnt;
                rd_phase = 1'b1;
                if (rd_b && rom_last) next_state = ROM_WR;
            end
            ROM_WR: begin
                mem_cs    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = cnt;
                mem_wdata = '1;
                if (rom_last) next_state = ROM_RD2;
            end
            ROM_RD2, ROM_RD3: begin
                mem_cs   = 1'b1;
                mem_addr = cnt;
                rd_phase = 1'b1;
                if (rd_b && rom_last) begin
                    if (sum_now != rom_sum) begin
                        fail       = 1'b1;
                        fail_code  = (state == ROM_RD2) ? 3'd1 : 3'd4;
                        next_state = DONE;
                    end else begin
                        next_state = (state == ROM_RD2) ? RAM_WR : DONE;
                    end
                end
            end
            RAM_WR: begin
                mem_cs    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = RAM_BASE + cnt;
                mem_wdata = pat;
                if (ram_last) next_state = RAM_RD;
            end
            RAM_RD, RAM_RD0: begin
                mem_cs   = 1'b1;
                mem_addr = RAM_BASE + cnt;
                rd_phase = 1'b1;
                if (rd_b) begin
                    if (mem_rdata != ((state == RAM_RD) ? pat : '0)) begin
                        fail       = 1'b1;
                        fail_code  = (state == RAM_RD) ? 3'd2 : 3'd3;
                        next_state = DONE;
                    end else if (ram_last) begin
                        next_state = (state == RAM_RD) ? CLR : ROM_RD3;
                    end
                end
            end
            CLR: begin
                mem_clr    = 1'b1;
                next_state = GAP;
            end
            GAP: begin
                next_state = RAM_RD0;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            cnt      <= '0;
            rd_b     <= 1'b0;
            acc      <= '0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_code <= 3'd0;
            err_addr <= '0;
            rom_sum  <= '0;
        end else begin
            state <= next_state;
            // Each phase starts from its base address with a fresh accumulator.
            if (next_state != state) begin
                cnt  <= '0;
                rd_b <= 1'b0;
                acc  <= '0;
            end else if (rd_phase) begin
                rd_b <= ~rd_b;
                if (rd_b) begin
                    cnt <= cnt + ADDR_BITS'(1);
                    acc <= sum_now;
                end
            end else if (mem_we) begin
                cnt <= cnt + ADDR_BITS'(1);
            end

            if (start_ok) begin
                done     <= 1'b0;
                pass     <= 1'b0;
                err_code <= 3'd0;
                err_addr <= '0;
                rom_sum  <= '0;
            end
            if (state == ROM_RD1 && rd_b && rom_last) rom_sum <= sum_now;
            if (fail) begin
                err_code <= fail_code;
                err_addr <= mem_addr;
            end
            if (next_state == DONE && state != DONE) begin
                done <= 1'b1;
                pass <= ~fail;
            end
        end
    end

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// tb/tb_mem_bist_ctrl.sv - self-checking bench for mem_bist_ctrl with a faultable memory model
module tb_mem_bist_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        start;
    logic [7:0]  mem_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we, mem_cs, mem_clr;
    logic        busy, done, pass;
    logic [2:0]  err_code;
    logic [15:0] err_addr;
    logic [15:0] rom_sum;

    mem_bist_ctrl #(
        .ADDR_BITS(16), .DATA_BITS(8), .ROM_SIZE(16), .ROM_TEST_LEN(4), .RAM_TEST_LEN(4)
    ) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_cs(mem_cs),
        .mem_clr(mem_clr), .busy(busy), .done(done), .pass(pass),
        .err_code(err_code), .err_addr(err_addr), .rom_sum(rom_sum)
    );

    always #5 CLK = ~CLK;

    // Memory modes: 0 good, 1 ROM writable, 2 bit0 stuck-at-0 at 18, 3 clear ignored
    int         mode = 0;
    logic       reload = 1'b0;
    logic [7:0] mem [0:31];

    always @(posedge CLK) begin
        if (reload) begin
            for (int i = 0; i < 32; i++) mem[i] <= (i < 4) ? 8'(8'h10 + i) : 8'h00;
            mem_rdata <= 8'h00;
        end else begin
            if (mem_clr && mode != 3)
                for (int i = 16; i < 32; i++) mem[i] <= 8'h00;
            if (mem_cs && mem_we && (mem_addr >= 16'd16 || mode == 1))
                mem[mem_addr[4:0]] <= (mode == 2 && mem_addr == 16'd18) ? (mem_wdata & 8'hFE) : mem_wdata;
            if (mem_cs && !mem_we)
                mem_rdata <= mem[mem_addr[4:0]];
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Expected per-cycle pins {busy,done,cs,we,clr,addr,wdata} and final status
    logic [28:0] exp_q[$];
    int          exp_code, exp_addr, exp_clr;
    logic [15:0] exp_sum;

    task automatic push(input logic cs, input logic we, input logic clr, input int a, input int wd);
        exp_q.push_back({1'b1, 1'b0, cs, we, clr, 16'(a), 8'(wd)});
    endtask

    task automatic push_rd(input int a);
        push(1, 0, 0, a, 0);
        push(1, 0, 0, a, 0);
    endtask

    task automatic build_expect(input int m);
        logic [7:0] rom [0:3];
        logic [7:0] ram [0:3];
        int s0, s;
        exp_q.delete();
        exp_clr = 0;
        exp_code = 0;
        exp_addr = 0;
        s0 = 0;
        for (int a = 0; a < 4; a++) begin
            rom[a] = 8'(8'h10 + a);
            ram[a] = 8'h00;
            s0 += rom[a];
        end
        exp_sum = 16'(s0);
        for (int a = 0; a < 4; a++) push_rd(a);
        for (int a = 0; a < 4; a++) begin
            push(1, 1, 0, a, 8'hFF);
            if (m == 1) rom[a] = 8'hFF;
        end
        s = 0;
        for (int a = 0; a < 4; a++) begin
            push_rd(a);
            s += rom[a];
        end
        if (16'(s) != exp_sum) begin
            exp_code = 1; exp_addr = 3;
            return;
        end
        for (int i = 0; i < 4; i++) begin
            push(1, 1, 0, 16 + i, i + 1);
            ram[i] = 8'(i + 1);
            if (m == 2 && i == 2) ram[i] = ram[i] & 8'hFE;
        end
        for (int i = 0; i < 4; i++) begin
            push_rd(16 + i);
            if (ram[i] != 8'(i + 1)) begin
                exp_code = 2; exp_addr = 16 + i;
                return;
            end
        end
        push(0, 0, 1, 0, 0);
        exp_clr = 1;
        if (m != 3) for (int i = 0; i < 4; i++) ram[i] = 8'h00;
        push(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            push_rd(16 + i);
            if (ram[i] != 8'h00) begin
                exp_code = 3; exp_addr = 16 + i;
                return;
            end
        end
        s = 0;
        for (int a = 0; a < 4; a++) begin
            push_rd(a);
            s += rom[a];
        end
        if (16'(s) != exp_sum) begin
            exp_code = 4; exp_addr = 3;
        end
    endtask

    logic armed = 1'b0;
    int   clr_cnt = 0;
    int   step = 0;

    always @(negedge CLK) begin
        checks++;
        if (mem_we && !mem_cs) begin
            errors++;
            $display("FAIL we_implies_cs: got we=%0b cs=%0b, expected cs=1", mem_we, mem_cs);
        end
        if (!mem_we && mem_wdata != 8'h00) begin
            errors++;
            $display("FAIL wdata_idle: got %h, expected 00", mem_wdata);
        end
        if (mem_clr) clr_cnt++;
        if (armed) begin
            if (exp_q.size() == 0) begin
                armed = 1'b0;
            end else begin
                check($sformatf("trace[%0d]", step),
                      64'({busy, done, mem_cs, mem_we, mem_clr, mem_addr, mem_wdata}),
                      64'(exp_q.pop_front()));
                step++;
                if (exp_q.size() == 0) armed = 1'b0;
            end
        end
    end

    task automatic do_reload();
        @(negedge CLK) reload = 1'b1;
        @(negedge CLK) reload = 1'b0;
    endtask

    task automatic run_mode(input int m, input bit pulses);
        int i;
        mode = m;
        do_reload();
        build_expect(m);
        step = 0;
        clr_cnt = 0;
        @(negedge CLK) start = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
        armed = 1'b1;
        i = 0;
        while (armed && i < 400) begin
            @(posedge CLK);
            #1 start = pulses && armed && (i % 7 == 3);
            i++;
        end
        start = 1'b0;
        if (armed) begin
            errors++;
            checks++;
            $display("FAIL run_timeout mode %0d: got still busy, expected done", m);
            armed = 1'b0;
            exp_q.delete();
        end
        check($sformatf("m%0d_done", m), 64'(done), 64'(1));
        check($sformatf("m%0d_busy", m), 64'(busy), 64'(0));
        check($sformatf("m%0d_pass", m), 64'(pass), 64'(exp_code == 0));
        check($sformatf("m%0d_err_code", m), 64'(err_code), 64'(exp_code));
        check($sformatf("m%0d_err_addr", m), 64'(err_addr), 64'(exp_addr));
        check($sformatf("m%0d_rom_sum", m), 64'(rom_sum), 64'(exp_sum));
        check($sformatf("m%0d_mem_idle", m), 64'({mem_cs, mem_we, mem_clr}), 64'(0));
        check($sformatf("m%0d_clr_cycles", m), 64'(clr_cnt), 64'(exp_clr));
        repeat (4) @(negedge CLK);
        check($sformatf("m%0d_done_held", m), 64'({done, busy}), 64'(2'b10));
    endtask

    initial begin
        RESET = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_mem", 64'({mem_addr, mem_wdata, mem_we, mem_cs, mem_clr}), 64'(0));
        check("rst_stat", 64'({busy, done, pass, err_code, err_addr, rom_sum}), 64'(0));
        RESET = 1'b0;

        run_mode(0, 1'b0);
        check("lit_rom_sum", 64'(rom_sum), 64'(16'h0046));
        check("lit_pass", 64'({pass, err_code, err_addr}), 64'({1'b1, 3'd0, 16'd0}));
        run_mode(1, 1'b0);
        check("lit_rom_alter", 64'({pass, err_code, err_addr}), 64'({1'b0, 3'd1, 16'd3}));
        run_mode(2, 1'b0);
        check("lit_ram_stuck", 64'({err_code, err_addr}), 64'({3'd2, 16'd18}));
        run_mode(3, 1'b0);
        check("lit_no_clear", 64'({err_code, err_addr}), 64'({3'd3, 16'd16}));

        // Abort mid RAM_WR, then a clean run must still pass
        mode = 0;
        do_reload();
        @(negedge CLK) start = 1'b1;
        @(negedge CLK) start = 1'b0;
        begin
            int k;
            k = 0;
            while (!(mem_we && mem_addr == 16'd17) && k < 200) begin
                @(negedge CLK);
                k++;
            end
            check("abort_reached_ram_wr", 64'({mem_we, mem_addr}), 64'({1'b1, 16'd17}));
        end
        #2 RESET = 1'b1;
        #1;
        check("abort_mem", 64'({mem_addr, mem_wdata, mem_we, mem_cs, mem_clr}), 64'(0));
        check("abort_stat", 64'({busy, done, pass, err_code, err_addr, rom_sum}), 64'(0));
        @(negedge CLK) RESET = 1'b0;
        run_mode(0, 1'b0);
        check("lit_after_abort", 64'({pass, rom_sum}), 64'({1'b1, 16'h0046}));

        run_mode(0, 1'b1);
        check("lit_restart_ignored", 64'({pass, err_code, rom_sum}), 64'({1'b1, 3'd0, 16'h0046}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
